// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the single register-file write port between the
// pipeline write-back stage and a small FIFO of multiply/divide results.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        MdValid,
  input  logic [4:0]  MdRd,
  input  logic [31:0] MdResult,
  output logic        MdReady,
  output logic        RfWE,
  output logic [4:0]  RfA3,
  output logic [31:0] RfWD,
  output logic        StallW,
  output logic [3:0]  MdPending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [3:0]    DEPTH_C = 4'(DEPTH);
  localparam logic [CW-1:0] SMAX_C  = CW'(STARVE_MAX);

  logic [4:0]    r_rd_mem   [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [3:0]    r_count;
  logic [CW-1:0] r_starve;

  logic w_empty;
  logic w_pipe_vld;
  logic w_starved;
  logic w_enq;
  logic w_deq;
  logic w_pipe_win;

  assign w_empty    = (r_count == 4'd0);
  assign w_pipe_vld = RegWriteW && (RdW != 5'd0);
  assign w_starved  = (r_starve == SMAX_C) && !w_empty;
  // Readiness looks only at stored occupancy, so a same-cycle dequeue never frees a slot early.
  assign MdReady    = !reset && (r_count < DEPTH_C);
  assign w_enq      = MdValid && MdReady && (MdRd != 5'd0);
  assign MdPending  = r_count;

  // Write-port priority: starved MD head, then pipeline, then MD head, else idle.
  always_comb begin
    RfWE       = 1'b0;
    RfA3       = 5'd0;
    RfWD       = 32'd0;
    StallW     = 1'b0;
    w_deq      = 1'b0;
    w_pipe_win = 1'b0;
    if (reset) begin
      RfWE = 1'b0;
    end else if (w_starved) begin
      RfWE   = 1'b1;
      RfA3   = r_rd_mem[r_rptr];
      RfWD   = r_data_mem[r_rptr];
      StallW = 1'b1;
      w_deq  = 1'b1;
    end else if (w_pipe_vld) begin
      RfWE       = 1'b1;
      RfA3       = RdW;
      RfWD       = ResultW;
      w_pipe_win = 1'b1;
    end else if (!w_empty) begin
      RfWE  = 1'b1;
      RfA3  = r_rd_mem[r_rptr];
      RfWD  = r_data_mem[r_rptr];
      w_deq = 1'b1;
    end else begin
      RfWE = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd_mem[r_wptr]   <= MdRd;
      r_data_mem[r_wptr] <= MdResult;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= 4'd0;
      r_starve <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      // Counts pipeline wins while MD results wait; any dequeue restarts the window.
      if (w_deq || w_empty) begin
        r_starve <= '0;
      end else if (w_pipe_win) begin
        r_starve <= r_starve + CW'(1);
      end else begin
        r_starve <= r_starve;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the write-port priority rules.
module tb_wb_port_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        reset;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        MdValid;
  logic [4:0]  MdRd;
  logic [31:0] MdResult;
  logic        MdReady;
  logic        RfWE;
  logic [4:0]  RfA3;
  logic [31:0] RfWD;
  logic        StallW;
  logic [3:0]  MdPending;

  int checks   = 0;
  int failures = 0;

  logic [36:0] mq[$];
  int          wins = 0;

  logic        o_ready;
  logic        o_we;
  logic [4:0]  o_a3;
  logic [31:0] o_wd;
  logic        o_stall;
  logic [3:0]  o_pending;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .MdValid(MdValid), .MdRd(MdRd), .MdResult(MdResult), .MdReady(MdReady),
    .RfWE(RfWE), .RfA3(RfA3), .RfWD(RfWD), .StallW(StallW), .MdPending(MdPending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, compare against the model, then advance the model.
  task automatic cyc(input logic rst, input logic rwe, input logic [4:0] rdw,
                     input logic [31:0] resw, input logic mv, input logic [4:0] mrd,
                     input logic [31:0] mres);
    logic        e_ready, e_we, e_stall, starved, deq, pipe;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic [36:0] head;
    int          sz;
    reset = rst; RegWriteW = rwe; RdW = rdw; ResultW = resw;
    MdValid = mv; MdRd = mrd; MdResult = mres;
    #1;
    sz      = mq.size();
    head    = (sz > 0) ? mq[0] : 37'd0;
    e_ready = !rst && (sz < DEPTH);
    pipe    = rwe && (rdw != 5'd0);
    starved = !rst && (sz > 0) && (wins == STARVE_MAX);
    e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0; e_stall = 1'b0; deq = 1'b0;
    if (!rst) begin
      if (starved) begin
        e_we = 1'b1; e_a3 = head[36:32]; e_wd = head[31:0]; e_stall = 1'b1; deq = 1'b1;
      end else if (pipe) begin
        e_we = 1'b1; e_a3 = rdw; e_wd = resw;
      end else if (sz > 0) begin
        e_we = 1'b1; e_a3 = head[36:32]; e_wd = head[31:0]; deq = 1'b1;
      end
    end
    o_ready = MdReady; o_we = RfWE; o_a3 = RfA3; o_wd = RfWD;
    o_stall = StallW; o_pending = MdPending;
    chk("MdReady",   32'(o_ready),   32'(e_ready));
    chk("RfWE",      32'(o_we),      32'(e_we));
    chk("RfA3",      32'(o_a3),      32'(e_a3));
    chk("RfWD",      o_wd,           e_wd);
    chk("StallW",    32'(o_stall),   32'(e_stall));
    chk("MdPending", 32'(o_pending), sz);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      wins = 0;
    end else begin
      if (deq) void'(mq.pop_front());
      if (mv && e_ready && (mrd != 5'd0)) mq.push_back({mrd, mres});
      if (deq || sz == 0) wins = 0;
      else if (pipe) wins++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int accepted;
    int busy_pct;
    reset = 1'b1; RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0;
    MdValid = 1'b0; MdRd = 5'd0; MdResult = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state and first cycle after reset
    cyc(1'b1, 1'b1, 5'd4, 32'h55, 1'b1, 5'd6, 32'h66);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_we", 32'(o_we), 32'd0);
    idle();
    chk("post_rst_ready", 32'(o_ready), 32'd1);
    chk("post_rst_pending", 32'(o_pending), 32'd0);

    // Single MD result into an idle pipeline
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    idle();
    chk("md_write_we", 32'(o_we), 32'd1);
    chk("md_write_a3", 32'(o_a3), 32'd5);
    chk("md_write_wd", o_wd, 32'h1234);
    idle();
    chk("md_drained", 32'(o_pending), 32'd0);

    // Starvation: pipeline writes every cycle, one MD result waits
    cyc(1'b0, 1'b1, 5'd3, 32'h30, 1'b1, 5'd7, 32'h77);
    for (int i = 0; i < STARVE_MAX; i++) begin
      cyc(1'b0, 1'b1, 5'd3, 32'h31 + i, 1'b0, 5'd0, 32'd0);
      chk("starve_pipe_stall", 32'(o_stall), 32'd0);
      chk("starve_pipe_a3", 32'(o_a3), 32'd3);
    end
    cyc(1'b0, 1'b1, 5'd3, 32'h40, 1'b0, 5'd0, 32'd0);
    chk("starve_stall", 32'(o_stall), 32'd1);
    chk("starve_a3", 32'(o_a3), 32'd7);
    chk("starve_wd", o_wd, 32'h77);
    cyc(1'b0, 1'b1, 5'd3, 32'h41, 1'b0, 5'd0, 32'd0);
    chk("starve_resume_stall", 32'(o_stall), 32'd0);
    chk("starve_resume_a3", 32'(o_a3), 32'd3);

    // Buffer full: third back-to-back result must wait for a dequeue
    cyc(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd11, 32'h111);
    cyc(1'b0, 1'b1, 5'd3, 32'hB, 1'b1, 5'd12, 32'h222);
    cyc(1'b0, 1'b1, 5'd3, 32'hC, 1'b1, 5'd13, 32'h333);
    chk("full_ready", 32'(o_ready), 32'd0);
    chk("full_pending", 32'(o_pending), 32'd2);
    accepted = 0;
    for (int i = 0; i < 12 && accepted == 0; i++) begin
      cyc(1'b0, 1'b1, 5'd3, 32'hD, 1'b1, 5'd13, 32'h333);
      if (o_ready) accepted = 1;
    end
    chk("full_third_accepted", accepted, 32'd1);
    for (int i = 0; i < 10 && mq.size() > 0; i++) idle();
    chk("full_drained", 32'(MdPending), 32'd0);

    // Register zero on both sources is never written
    cyc(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    chk("r0_we", 32'(o_we), 32'd0);
    idle();
    chk("r0_pending", 32'(o_pending), 32'd0);
    chk("r0_we_next", 32'(o_we), 32'd0);

    // Mid-operation reset drops buffered results
    cyc(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd9, 32'h999);
    cyc(1'b0, 1'b1, 5'd3, 32'h2, 1'b1, 5'd10, 32'hAAA);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("mid_rst_pending_before", 32'(o_pending), 32'd2);
    chk("mid_rst_we", 32'(o_we), 32'd0);
    idle();
    chk("mid_rst_after_we", 32'(o_we), 32'd0);
    chk("mid_rst_after_pending", 32'(o_pending), 32'd0);
    chk("mid_rst_after_ready", 32'(o_ready), 32'd1);

    // Randomized traffic with alternating pipeline load and occasional resets
    for (int n = 0; n < 3000; n++) begin
      busy_pct = ((n / 300) % 2 == 0) ? 90 : 30;
      cyc(($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < busy_pct),
          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
          $urandom(),
          ($urandom_range(0, 99) < 50),
          ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
          $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the multiply/divide (MD) result buffer depth in entries (power of two, 2..8).
REQ-002 Parameter STARVE_MAX, default 4, SHALL set the number of consecutive cycles the pipeline may win while MD results wait.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 RegWriteW  in  1  SHALL be the write-back stage write enable.
REQ-006 RdW  in  5  SHALL be the write-back stage destination register.
REQ-007 ResultW  in  32  SHALL be the write-back stage result.
REQ-008 MdValid  in  1  SHALL be the MD unit result valid.
REQ-009 MdRd  in  5  SHALL be the MD unit destination register.
REQ-010 MdResult  in  32  SHALL be the MD unit result data.
REQ-011 MdReady  out  1  SHALL be high when the buffer can accept an MD result.
REQ-012 RfWE  out  1  SHALL be the register-file write enable.
REQ-013 RfA3  out  5  SHALL be the register-file write address.
REQ-014 RfWD  out  32  SHALL be the register-file write data.
REQ-015 StallW  out  1  SHALL freeze the write-back stage for the current cycle.
REQ-016 MdPending  out  4  SHALL report the current buffer occupancy.

Function
REQ-017 An MD handshake SHALL occur when MdValid and MdReady are both high; the result is enqueued in FIFO order.
REQ-018 A handshake with MdRd==0 SHALL be accepted and discarded; it is not enqueued.
REQ-019 MdReady SHALL be derived from registered occupancy only: high iff MdPending < DEPTH, including in cycles where a dequeue occurs.
REQ-020 MD results SHALL have no bypass path: earliest register-file write is the cycle after the handshake.
REQ-021 A pipeline request SHALL be valid when RegWriteW is high and RdW != 0; RdW==0 requests never drive RfWE.
REQ-022 Priority SHALL be evaluated each cycle: (a) starved: buffer head written, StallW=1; (b) otherwise, valid pipeline request written, StallW=0; (c) otherwise, if the buffer is non-empty, head written; (d) otherwise RfWE=0.
REQ-023 The block SHALL be in the starved state when the starvation counter == STARVE_MAX and the buffer is non-empty.
REQ-024 The starvation counter SHALL increment when the buffer is non-empty and case (b) is taken. It SHALL clear when the buffer dequeues or is empty, and hold otherwise.
REQ-025 StallW SHALL be high only in the starved state, never for more than one consecutive cycle, and regardless of the RegWriteW value.
REQ-026 When RfWE=0, RfA3 and RfWD SHALL be 0.
REQ-027 A simultaneous enqueue and dequeue SHALL leave MdPending unchanged and preserve order; read and write pointers wrap modulo DEPTH.
REQ-028 The block SHALL NOT check WAW ordering between pipeline and MD destinations; the issue scoreboard guarantees no overlap.

Reset
REQ-029 While reset is high, the buffer SHALL be emptied, pointers and the starvation counter zeroed, and MD handshakes ignored.
REQ-030 During and in the cycle after reset: MdPending=0, MdReady=0 while reset is high and 1 after, StallW=0, RfWE=0 unless a valid pipeline request is present after reset.
REQ-031 Reset asserted mid-operation SHALL drop all buffered results without writing them.

Verification
REQ-032 Idle pipeline, MD handshake Rd=5, data=0x1234 at cycle t -> RfWE=1, RfA3=5, RfWD=0x1234 at t+1; MdPending back to 0 at t+2.
REQ-033 Pipeline writes every cycle (Rd=3), one MD result Rd=7 enqueued, STARVE_MAX=4 -> four pipeline writes, then one cycle StallW=1 with Rd=7 written, then pipeline resumes.
REQ-034 DEPTH=2, pipeline busy, three back-to-back MdValid -> first two accepted, MdReady=0 on the third, MdPending=2; the third is accepted only after a dequeue cycle.
REQ-035 MD handshake with MdRd=0 and pipeline RdW=0 with RegWriteW=1 -> no RfWE, MdPending stays 0.
REQ-036 Buffer holding two entries, reset pulsed one cycle -> no RfWE for buffered data; MdPending=0, MdReady=1 the cycle after reset deasserts.
